// File: rtl/apb_master_pkg.sv
// Shared definitions for the APB master: FSM encoding, one-hot slave select codes
// and the default ACCESS-phase wait limit.
package apb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_t;

  localparam logic [1:0] PSEL_GPIO       = 2'b01;
  localparam logic [1:0] PSEL_UART       = 2'b10;
  localparam int         TIMEOUT_DEFAULT = 16;

  function automatic logic [1:0] psel_code(input logic sel);
    return sel ? PSEL_UART : PSEL_GPIO;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS-phase wait cycles; expired flags the terminal count TIMEOUT-1.
module apb_wait_timer
  import apb_master_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: accepts one command, runs SETUP/ACCESS on the bus,
// and returns read data / error (slave error or wait timeout) as a response.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_sel,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] pAdd,
  output logic [31:0] pwData,
  output logic [1:0]  psel,
  output logic        pen,
  output logic        pwr,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        err_in,
  output apb_state_t  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // a raised valid and its payload are held until that edge.
  apb_state_t state;
  logic       expired;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == ST_SETUP),
    .enable  ((state == ST_ACCESS) && !pready),
    .expired (expired)
  );

  // The command registers double as the APB address/data/write outputs; they are
  // loaded at the handshake and cleared when the bus phase ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      pAdd      <= '0;
      pwData    <= '0;
      psel      <= '0;
      pen       <= 1'b0;
      pwr       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            state     <= ST_SETUP;
            cmd_ready <= 1'b0;
            psel      <= psel_code(cmd_sel);
            pwr       <= cmd_write;
            pAdd      <= cmd_addr;
            pwData    <= cmd_wdata;
          end
        end
        ST_SETUP: begin
          pen   <= 1'b1;
          state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // pready on the terminal-count cycle takes priority over the timeout.
          if (pready || expired) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= pready ? err_in : 1'b1;
            rsp_rdata <= (pready && !pwr) ? prdata : '0;
            psel      <= '0;
            pen       <= 1'b0;
            pwr       <= 1'b0;
            pAdd      <= '0;
            pwData    <= '0;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master (TIMEOUT = 4): directed cases plus random transfers, each
// checked against a transaction-level model of latency, response data and error.
module tb_apb_master;
  import apb_master_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, cmd_sel = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        cmd_ready;
  logic        rsp_valid, rsp_err;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [31:0] pAdd, pwData, prdata = '0;
  logic [1:0]  psel;
  logic        pen, pwr;
  logic        pready = 1'b0, err_in = 1'b0;
  apb_state_t  dbg_state;

  int unsigned edges = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [39:0] exp_q[$];

  apb_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .pAdd(pAdd), .pwData(pwData), .psel(psel), .pen(pen), .pwr(pwr),
    .prdata(prdata), .pready(pready), .err_in(err_in), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Drive one command and act as the slave. The model: a slave that delays wait_n
  // cycles completes in wait_n+1 ACCESS cycles unless wait_n >= TO, in which case
  // the master gives up after TO cycles with err=1, rdata=0. Writes return rdata 0.
  task automatic run_txn(input logic wr, input logic sel, input logic [31:0] addr,
                         input logic [31:0] wdata, input int wait_n, input logic err,
                         input logic [31:0] rd, input int rsp_delay);
    int          acc_exp, acc;
    int unsigned hs;
    logic [1:0]  ps_exp;
    logic [39:0] e;
    ps_exp = sel ? 2'b10 : 2'b01;
    if (wait_n >= TO) begin
      acc_exp = TO;
      e = {7'(TO), 1'b1, 32'h0};
    end else begin
      acc_exp = wait_n + 1;
      e = {7'(acc_exp), err, wr ? 32'h0 : rd};
    end
    exp_q.push_back(e);

    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    check("idle_paddr", pAdd, 0);
    check("idle_psel", psel, 0);
    cmd_valid = 1'b1; cmd_write = wr; cmd_sel = sel; cmd_addr = addr; cmd_wdata = wdata;
    @(posedge clk); #1;
    hs = edges;
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_sel = 1'($urandom);
    cmd_addr = $urandom; cmd_wdata = $urandom;

    @(negedge clk);
    check("setup_psel", psel, ps_exp);
    check("setup_pen", pen, 0);
    check("setup_paddr", pAdd, addr);
    check("setup_pwdata", pwData, wdata);
    check("setup_pwr", pwr, wr);
    check("setup_cmd_ready", cmd_ready, 0);

    acc = 0;
    for (int g = 0; g < 300; g++) begin
      @(negedge clk);
      if (!pen) break;
      acc++;
      check("access_psel", psel, ps_exp);
      check("access_paddr", pAdd, addr);
      check("access_pwdata", pwData, wdata);
      check("access_pwr", pwr, wr);
      pready = ((acc - 1) == wait_n);
      err_in = pready ? err : 1'($urandom);
      prdata = pready ? rd : $urandom;
    end
    pready = 1'b0; err_in = 1'b0; prdata = $urandom;

    e = exp_q.pop_front();
    check("resp_valid", rsp_valid, 1);
    check("resp_acc_err_rdata", {7'(acc), rsp_err, rsp_rdata}, e);
    check("resp_latency", edges - hs, 1 + acc_exp);
    check("resp_psel", psel, 0);
    check("resp_pen", pen, 0);
    for (int i = 0; i < rsp_delay; i++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_resp", {rsp_err, rsp_rdata}, e[32:0]);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("done_valid", rsp_valid, 0);
    check("done_cmd_ready", cmd_ready, 1);
    check("done_pwdata", pwData, 0);
    check("done_pwr", pwr, 0);
  endtask

  task automatic reset_in_access();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_sel = 1'b1;
    cmd_addr = 32'h0000_0044; cmd_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_pen", pen, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_psel", psel, 0);
    check("rst_pen", pen, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_paddr", pAdd, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_no_rsp", rsp_valid, 0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp", {rsp_err, rsp_rdata}, 0);
    check("reset_bus", {psel, pen, pwr, pAdd, pwData}, 0);
    rst_n = 1'b1;

    run_txn(1'b1, 1'b1, 32'h0000_0010, 32'hA5A5_1234, 0, 1'b0, 32'h5555_AAAA, 0);
    run_txn(1'b0, 1'b0, 32'h0000_0020, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 1);
    run_txn(1'b0, 1'b1, 32'h0000_0030, 32'h0, 50, 1'b0, 32'hCAFE_F00D, 1);
    run_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0BAD_0BAD, 0, 1'b1, 32'h0, 5);
    run_txn(1'b1, 1'b1, 32'h0000_0050, 32'h7777_1111, TO - 1, 1'b0, 32'h1, 0);
    reset_in_access();

    for (int t = 0; t < 25; t++) begin
      run_txn(1'($urandom), 1'($urandom), $urandom, $urandom,
              $urandom_range(0, TO + 1), ($urandom_range(0, 3) == 0),
              $urandom, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
